sd_spi_master: RTL and testbench

- Core-side SPI master that drives the ss/sck/mosi/miso pins of the emulated SD card (the SPI slave in the sys layer).
- Converts single-byte requests and multi-byte block reads from the core's disk controller into SPI mode-0 transfers.
- Received block bytes are delivered on a valid/ready stream.
- Runs in the clk_sys domain. Guarantees the sck rate the card model needs: clk_spi at least 4 x sck.

---
 rtl/sd_spi_master_if.sv | 36 +++
 rtl/sd_spi_master.sv | 234 +++++++++++++++++++++++
 tb/tb_sd_spi_master.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_master_if.sv
// rtl/sd_spi_master_if.sv - signal bundle between the disk controller, sd_spi_master and the SD card pins
//   core requests : cs_assert, tx_start, tx_data, blk_start, blk_len
//   core results  : rx_data, rx_valid, blk_data, blk_valid, blk_ready, blk_done, busy, crc16
//   SPI pins      : ss, sck, mosi, miso
//   modport master: the SPI master (sd_spi_master); modport slave: the core/card side
interface sd_spi_master_if #(
  parameter int BLK_W = 10
);
  logic             cs_assert;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             blk_start;
  logic [BLK_W-1:0] blk_len;
  logic [7:0]       blk_data;
  logic             blk_valid;
  logic             blk_ready;
  logic             blk_done;
  logic             busy;
  logic             ss;
  logic             sck;
  logic             mosi;
  logic             miso;
  logic [15:0]      crc16;

  modport master (
    input  cs_assert, tx_start, tx_data, blk_start, blk_len, blk_ready, miso,
    output rx_data, rx_valid, blk_data, blk_valid, blk_done, busy, ss, sck, mosi, crc16
  );

  modport slave (
    output cs_assert, tx_start, tx_data, blk_start, blk_len, blk_ready, miso,
    input  rx_data, rx_valid, blk_data, blk_valid, blk_done, busy, ss, sck, mosi, crc16
  );
endinterface

// File: rtl/sd_spi_master.sv
// rtl/sd_spi_master.sv - SPI mode-0 master for the emulated SD card: single bytes and block reads
//   clk_sys : system clock, all logic in this domain
//   reset   : asynchronous, active-high
//   bus     : sd_spi_master_if.master (core requests/results, block stream, SPI pins)
//   CLK_DIV : sck half-period in clk_sys cycles (clamped to 2..255)
//   BLK_W   : blk_len width; blk_len=0 reads 512 bytes
//   SD_SPI_CRC16_EN : when defined, crc16 carries CRC-16-CCITT of accepted block bytes
module sd_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int BLK_W   = 10
) (
  input  logic            clk_sys,
  input  logic            reset,
  sd_spi_master_if.master bus
);

  localparam int               DIV      = (CLK_DIV < 2) ? 2 : ((CLK_DIV > 255) ? 255 : CLK_DIV);
  localparam logic [7:0]       DIV_LAST = 8'(DIV - 1);
  localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(512);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCK_LO,
    SCK_HI,
    BYTE_END,
    BLK_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             is_blk_q, is_blk_d;
  logic [BLK_W-1:0] cnt_q, cnt_d;
  logic             ss_q, ss_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       blk_data_q, blk_data_d;
  logic             blk_valid_q, blk_valid_d;
  logic             blk_done_q, blk_done_d;
  logic             busy_q, busy_d;

`ifdef SD_SPI_CRC16_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    is_blk_d    = is_blk_q;
    cnt_d       = cnt_q;
    ss_d        = ss_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    blk_data_d  = blk_data_q;
    blk_valid_d = blk_valid_q;
    blk_done_d  = 1'b0;
    busy_d      = busy_q;
`ifdef SD_SPI_CRC16_EN
    crc_d       = crc_q;
`endif

    case (state_q)
      IDLE: begin
        // chip select only tracks the core between transfers
        ss_d   = ~bus.cs_assert;
        sck_d  = 1'b0;
        mosi_d = 1'b1;
        if (bus.tx_start) begin
          shift_d  = bus.tx_data;
          is_blk_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = LOAD;
        end else if (bus.blk_start) begin
          shift_d  = 8'hFF;
          is_blk_d = 1'b1;
          cnt_d    = (bus.blk_len == '0) ? BLK_MAX : bus.blk_len;
          busy_d   = 1'b1;
`ifdef SD_SPI_CRC16_EN
          crc_d    = 16'h0000;
`endif
          state_d  = LOAD;
        end
      end

      LOAD: begin
        mosi_d  = shift_q[7];
        bit_d   = 3'd0;
        div_d   = 8'd0;
        state_d = SCK_LO;
      end

      SCK_LO: begin
        if (div_q == DIV_LAST) begin
          // shift out and in share one register: MSB leaves, miso enters at LSB
          sck_d   = 1'b1;
          shift_d = {shift_q[6:0], bus.miso};
          div_d   = 8'd0;
          state_d = SCK_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      SCK_HI: begin
        if (div_q == DIV_LAST) begin
          sck_d = 1'b0;
          div_d = 8'd0;
          if (bit_q == 3'd7) begin
            state_d = BYTE_END;
            // registered here so rx_valid is visible during the BYTE_END cycle
            if (!is_blk_q) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end
          end else begin
            mosi_d  = shift_q[7];
            bit_d   = bit_q + 3'd1;
            state_d = SCK_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      BYTE_END: begin
        mosi_d = 1'b1;
        if (is_blk_q) begin
          blk_data_d  = shift_q;
          blk_valid_d = 1'b1;
          state_d     = BLK_HOLD;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      BLK_HOLD: begin
        // sck is parked low until the consumer takes the byte
        if (blk_valid_q && bus.blk_ready) begin
          blk_valid_d = 1'b0;
          cnt_d       = cnt_q - BLK_W'(1);
`ifdef SD_SPI_CRC16_EN
          crc_d       = crc16_byte(crc_q, blk_data_q);
`endif
          if (cnt_q == BLK_W'(1)) begin
            blk_done_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            shift_d = 8'hFF;
            state_d = LOAD;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= 8'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      is_blk_q    <= 1'b0;
      cnt_q       <= '0;
      ss_q        <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      blk_data_q  <= 8'h00;
      blk_valid_q <= 1'b0;
      blk_done_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SD_SPI_CRC16_EN
      crc_q       <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      is_blk_q    <= is_blk_d;
      cnt_q       <= cnt_d;
      ss_q        <= ss_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      blk_data_q  <= blk_data_d;
      blk_valid_q <= blk_valid_d;
      blk_done_q  <= blk_done_d;
      busy_q      <= busy_d;
`ifdef SD_SPI_CRC16_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign bus.ss        = ss_q;
  assign bus.sck       = sck_q;
  assign bus.mosi      = mosi_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.blk_data  = blk_data_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_done  = blk_done_q;
  assign bus.busy      = busy_q;
`ifdef SD_SPI_CRC16_EN
  assign bus.crc16     = crc_q;
`else
  assign bus.crc16     = 16'h0000;
`endif

endmodule

// File: tb/tb_sd_spi_master.sv
// tb/tb_sd_spi_master.sv - self-checking bench for sd_spi_master with an SPI card model
module tb_sd_spi_master;
  localparam int CLK_DIV = 4;
  localparam int BLK_W   = 10;
  localparam int LAT     = 16 * CLK_DIV + 2;

  logic clk_sys = 1'b0;
  logic rst;
  always #5 clk_sys = ~clk_sys;

  sd_spi_master_if #(.BLK_W(BLK_W)) bus ();

  sd_spi_master #(.CLK_DIV(CLK_DIV), .BLK_W(BLK_W)) dut (
    .clk_sys (clk_sys),
    .reset   (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] tx;
    logic [7:0] reply;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
    logic       poke;
    logic       both;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int failures = 0;

  logic [7:0] sl_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_blk[$];
  logic [2:0] sl_bit = 3'd0;
  logic [7:0] sl_cur = 8'hFF;
  logic       sck_prev = 1'b0;
  logic       miso_r = 1'b1;
  logic [7:0] mosi_bits = 8'h00;
  int sck_pulses = 0;
  int rx_pulses = 0;
  int blk_seen = 0;
  int blk_done_cnt = 0;
  int hold_bad = 0;
  int idle_bad = 0;
  int ss_bad = 0;
  int mosi_zero = 0;
  logic ss_watch = 1'b0;
  logic blk_mode = 1'b0;
  logic [15:0] crc_model = 16'h0000;

  assign bus.miso = miso_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  // Card model and pin monitor: shifts on sck fall, presents MSB first
  always @(negedge clk_sys) begin
    if (rst) begin
      sl_bit = 3'd0;
      sl_q.delete();
    end else if (sck_prev && !bus.sck) begin
      if (sl_bit == 3'd7) begin
        sl_bit = 3'd0;
        if (sl_q.size() != 0) void'(sl_q.pop_front());
      end else begin
        sl_bit = sl_bit + 3'd1;
      end
    end
    if (!sck_prev && bus.sck) begin
      mosi_bits = {mosi_bits[6:0], bus.mosi};
      sck_pulses++;
    end
    sck_prev = bus.sck;
    sl_cur = (sl_q.size() != 0) ? sl_q[0] : 8'hFF;
    miso_r = sl_cur[3'd7 - sl_bit];

    if (!rst) begin
      if (bus.rx_valid) begin
        rx_pulses++;
        chk("rx_expected", 32'(exp_rx.size() != 0), 1);
        if (exp_rx.size() != 0) chk("rx_data", bus.rx_data, exp_rx.pop_front());
      end
      if (bus.blk_valid) blk_seen++;
      if (bus.blk_done) blk_done_cnt++;
      if (bus.blk_valid && bus.sck) hold_bad++;
      if (!bus.busy && bus.sck) idle_bad++;
      if (ss_watch && bus.busy && bus.ss) ss_bad++;
      if (blk_mode && !bus.mosi) mosi_zero++;
    end
  end

  task automatic run_tx(input vec_t v);
    int p0, r0, b0, n, lat;
    sl_q.push_back(v.reply);
    exp_rx.push_back(v.exp_rx);
    p0 = sck_pulses; r0 = rx_pulses; b0 = blk_seen; lat = -1;
    bus.tx_data   = v.tx;
    bus.blk_len   = BLK_W'(4);
    bus.tx_start  = 1'b1;
    bus.blk_start = v.both;
    @(negedge clk_sys);
    bus.tx_start  = 1'b0;
    bus.blk_start = 1'b0;
    n = 1;
    while (n < 1000) begin
      if (bus.rx_valid && lat < 0) lat = n;
      if (!bus.busy) break;
      if (v.poke && n == 20) begin
        bus.tx_data = 8'h00; bus.tx_start = 1'b1; bus.blk_start = 1'b1;
      end else begin
        bus.tx_data = v.tx; bus.tx_start = 1'b0; bus.blk_start = 1'b0;
      end
      @(negedge clk_sys);
      n++;
    end
    chk("tx_finished", 32'(n < 1000), 1);
    @(negedge clk_sys);
    chk("mosi_bits", mosi_bits, v.exp_mosi);
    chk("sck_pulses", sck_pulses - p0, 8);
    chk("rx_pulses", rx_pulses - r0, 1);
    chk("rx_latency", lat, LAT);
    chk("no_block_started", blk_seen - b0, 0);
  endtask

  task automatic run_blk(input logic [BLK_W-1:0] len, input int mode, input int nbytes);
    int acc, done0, hold0, mz0, t;
    logic [7:0] e;
    acc = 0; done0 = blk_done_cnt; hold0 = hold_bad; mz0 = mosi_zero;
    crc_model = 16'h0000;
    blk_mode = 1'b1;
    bus.blk_len   = len;
    bus.blk_start = 1'b1;
    @(negedge clk_sys);
    bus.blk_start = 1'b0;
    t = 0;
    while (t < 50000) begin
      bus.blk_ready = (mode == 0) || (t % 3 == 0);
      if (bus.blk_valid && bus.blk_ready) begin
        chk("blk_expected", 32'(exp_blk.size() != 0), 1);
        if (exp_blk.size() != 0) begin
          e = exp_blk.pop_front();
          chk("blk_data", bus.blk_data, e);
          crc_model = crc_ref(crc_model, e);
        end
        acc++;
      end
      if (!bus.busy) break;
      @(negedge clk_sys);
      t++;
    end
    chk("blk_finished", 32'(t < 50000), 1);
    @(negedge clk_sys);
    bus.blk_ready = 1'b0;
    blk_mode = 1'b0;
    chk("blk_count", acc, nbytes);
    chk("blk_done_pulses", blk_done_cnt - done0, 1);
    chk("sck_low_in_hold", hold_bad - hold0, 0);
    chk("mosi_high_in_blk", mosi_zero - mz0, 0);
`ifdef SD_SPI_CRC16_EN
    chk("crc16", bus.crc16, crc_model);
`else
    chk("crc16_off", bus.crc16, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r0, n, ssb0;
    rst = 1'b1;
    bus.cs_assert = 1'b0; bus.tx_start = 1'b0; bus.tx_data = 8'h00;
    bus.blk_start = 1'b0; bus.blk_len = '0;    bus.blk_ready = 1'b0;

    vecs[0] = '{8'h40, 8'hFF, 8'hFF, 8'h40, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 8'h7E, 8'h7E, 8'h81, 1'b0, 1'b0};
    vecs[5] = '{8'h69, 8'hC5, 8'hC5, 8'h69, 1'b0, 1'b1};

    repeat (3) @(negedge clk_sys);
    chk("rst_ss", bus.ss, 1);
    chk("rst_sck", bus.sck, 0);
    chk("rst_mosi", bus.mosi, 1);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_blk_valid", bus.blk_valid, 0);
    chk("rst_blk_data", bus.blk_data, 0);
    chk("rst_blk_done", bus.blk_done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_crc16", bus.crc16, 0);

    rst = 1'b0;
    @(negedge clk_sys);
    bus.cs_assert = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("ss_selected", bus.ss, 0);
    ss_watch = 1'b1;

    for (int i = 0; i < 6; i++) run_tx(vecs[i]);
    chk("ss_low_while_busy", ss_bad, 0);

    sl_q.push_back(8'hFE); sl_q.push_back(8'h12); sl_q.push_back(8'h34); sl_q.push_back(8'h56);
    exp_blk.push_back(8'hFE); exp_blk.push_back(8'h12); exp_blk.push_back(8'h34); exp_blk.push_back(8'h56);
    run_blk(BLK_W'(4), 0, 4);

    for (int i = 0; i < 512; i++) begin
      sl_q.push_back(8'(i * 7 + 3));
      exp_blk.push_back(8'(i * 7 + 3));
    end
    run_blk(BLK_W'(0), 1, 512);

    // chip select dropped mid-byte is only honoured once the byte is done
    sl_q.push_back(8'h5A);
    exp_rx.push_back(8'h5A);
    ssb0 = ss_bad;
    bus.tx_data = 8'hC3; bus.tx_start = 1'b1;
    @(negedge clk_sys);
    bus.tx_start = 1'b0;
    repeat (20) @(negedge clk_sys);
    bus.cs_assert = 1'b0;
    n = 0;
    while (bus.busy && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    chk("cs_tx_finished", 32'(n < 1000), 1);
    chk("ss_held_while_busy", ss_bad - ssb0, 0);
    chk("ss_first_idle", bus.ss, 0);
    @(negedge clk_sys);
    chk("ss_released", bus.ss, 1);

    // asynchronous reset in the middle of a byte
    bus.cs_assert = 1'b1;
    repeat (3) @(negedge clk_sys);
    sl_q.push_back(8'h77);
    r0 = rx_pulses;
    bus.tx_data = 8'h9C; bus.tx_start = 1'b1;
    @(negedge clk_sys);
    bus.tx_start = 1'b0;
    repeat (25) @(negedge clk_sys);
    chk("busy_before_reset", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sck", bus.sck, 0);
    chk("mid_rst_ss", bus.ss, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_mosi", bus.mosi, 1);
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst = 1'b0;
    repeat (100) @(negedge clk_sys);
    chk("no_rx_after_reset", rx_pulses - r0, 0);
    chk("no_blk_after_reset", bus.blk_valid, 0);
    chk("sck_quiet_when_idle", idle_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
